vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk  input  1  50 MHz system clock (CLOCK_50 at top).
REQ-010 SHALL have port reset  input  1  asynchronous active-low reset (KEY[0] at top).
REQ-011 SHALL have port pixel_tick  output  1  25 MHz pixel enable, high one clk in two.
REQ-012 SHALL have port pixel_x  output  10  horizontal counter, 0..H_TOTAL-1.
REQ-013 SHALL have port pixel_y  output  10  vertical counter, 0..V_TOTAL-1.
REQ-014 SHALL have port hsync  output  1  active-low horizontal sync to VGA_HS.
REQ-015 SHALL have port vsync  output  1  active-low vertical sync to VGA_VS.
REQ-016 SHALL have port video_on  output  1  high while in visible region.
REQ-017 SHALL have port frame_end  output  1  one-clk pulse when entering line V_VISIBLE at pixel 0.
REQ-018 SHALL have port frame_count  output  16  completed-frame count (see Configuration).

Function
REQ-019 SHALL define H_TOTAL = sum of H parameters (800) and V_TOTAL = sum of V parameters (525).
REQ-020 SHALL toggle an internal divider flop every clk; pixel_tick SHALL equal that flop.
REQ-021 SHALL advance pixel_x by 1 on each clk edge where pixel_tick=1; from H_TOTAL-1 wrap to 0.
REQ-022 SHALL advance pixel_y by 1 only on the pixel_x wrap; from V_TOTAL-1 wrap to 0 on the same edge.
REQ-023 SHALL drive hsync=0 exactly when H_VISIBLE+H_FRONT <= pixel_x < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1.
REQ-024 SHALL drive vsync=0 exactly when V_VISIBLE+V_FRONT <= pixel_y < V_VISIBLE+V_FRONT+V_SYNC (490..491), else 1.
REQ-025 SHALL register hsync and vsync from next-state counter values so they change on the same edge as pixel_x/pixel_y, glitch-free, zero relative latency.
REQ-026 SHALL drive video_on = (pixel_x < H_VISIBLE) && (pixel_y < V_VISIBLE), combinational from the counters.
REQ-027 SHALL assert frame_end for exactly one clk, the clk after counters become (x=0, y=V_VISIBLE), once per frame.
REQ-028 SHALL hold counters and syncs stable on clk edges where pixel_tick=0 (each value lasts exactly 2 clk).
REQ-029 SHALL give a frame period of exactly 2*800*525 = 840000 clk at defaults.

Reset
REQ-030 SHALL, while reset=0, asynchronously force pixel_tick=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, frame_end=0, frame_count=0.
REQ-031 SHALL, on reset assertion mid-line or mid-sync pulse, immediately abandon the frame; no partial sync pulse is resumed.
REQ-032 SHALL, after reset release, produce pixel_tick=1 on the first clk edge and first increment of pixel_x on the second edge.

Configuration
REQ-033 SHALL implement frame counting under macro VGA_FRAME_COUNT_EN.
REQ-034 SHALL, with VGA_FRAME_COUNT_EN defined, increment frame_count by 1 on each (H_TOTAL-1, V_TOTAL-1) -> (0,0) wrap, wrapping 65535 -> 0.
REQ-035 SHALL, without VGA_FRAME_COUNT_EN, tie frame_count to 0 and instantiate no counter flops.

Verification
REQ-036 Reset held 10 clk then released -> pixel_x=0, pixel_y=0, hsync=1, vsync=1 during reset; pixel_x=1 two edges after release.
REQ-037 Run one line -> hsync low for exactly 192 clk starting when pixel_x becomes 656; pixel_y increments when pixel_x 799 -> 0.
REQ-038 Run one frame -> vsync low exactly 3200 clk (y=490..491); video_on high 640*480*2 clk total; frame_end pulses once at (0,480).
REQ-039 Run two frames with VGA_FRAME_COUNT_EN -> frame_count 0 -> 1 -> 2, each step 840000 clk apart; without macro frame_count stays 0.
REQ-040 Assert reset at pixel_x=700, pixel_y=490 -> hsync and vsync return to 1 and counters to 0 within the same clk, without waiting for an edge.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, x/y raster counters and registered syncs.
// Optional completed-frame counter is built only when VGA_FRAME_COUNT_EN is defined.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pixel_tick,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_end,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  logic       tick_q, tick_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       fe_q, fe_d;

  always_comb begin
    tick_d = ~tick_q;
    x_d    = x_q;
    y_d    = y_q;
    if (tick_q) begin
      if (x_q == 10'(H_TOTAL - 1)) begin
        x_d = '0;
        if (y_q == 10'(V_TOTAL - 1)) y_d = '0;
        else                         y_d = y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Syncs decode the next counter values so they switch on the same edge as the counters.
    hs_d = !((x_d >= 10'(HS_START)) && (x_d < 10'(HS_END)));
    vs_d = !((y_d >= 10'(VS_START)) && (y_d < 10'(VS_END)));
    // Fires on the idle half of the first pixel of line V_VISIBLE, so once per frame.
    fe_d = (x_q == 10'd0) && (y_q == 10'(V_VISIBLE)) && !tick_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fe_q   <= 1'b0;
    end else begin
      tick_q <= tick_d;
      x_q    <= x_d;
      y_q    <= y_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fe_q   <= fe_d;
    end
  end

  assign pixel_tick = tick_q;
  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign frame_end  = fe_q;
  assign video_on   = (x_q < 10'(H_VISIBLE)) && (y_q < 10'(V_VISIBLE));

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q;
    if (tick_q && (x_q == 10'(H_TOTAL - 1)) && (y_q == 10'(V_TOTAL - 1)))
      fc_d = fc_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fc_q <= '0;
    else        fc_q <= fc_d;
  end

  assign frame_count = fc_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a shrunken-timing instance for full-frame behaviour and a
// default-timing instance for the 640x480 line timing.
module tb_vga_sync_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;   // 15
  localparam int VT = VV + VF + VS + VB;   // 8
  localparam int FP = HT * VT;             // 120 pixels per frame

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        s_tick, s_hs, s_vs, s_von, s_fe;
  logic [9:0]  s_x, s_y;
  logic [15:0] s_fc;

  logic        d_tick, d_hs, d_vs, d_von, d_fe;
  logic [9:0]  d_x, d_y;
  logic [15:0] d_fc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) u_small (
    .clk(clk), .reset(reset), .pixel_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .frame_end(s_fe), .frame_count(s_fc)
  );

  vga_sync_gen u_def (
    .clk(clk), .reset(reset), .pixel_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von), .frame_end(d_fe), .frame_count(d_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int p, ex, ey, fe_cnt, hs_low, vs_low, von_cnt, fe_n_first, fe_n_second;
    int def_first_x, def_low;
    bit found;
    logic [15:0] exp_fc;

    // Reset held for 10 clocks
    reset = 1'b0;
    repeat (10) step();
    chk("rst_x", s_x, 0);
    chk("rst_y", s_y, 0);
    chk("rst_hs", s_hs, 1);
    chk("rst_vs", s_vs, 1);
    chk("rst_tick", s_tick, 0);
    chk("rst_fe", s_fe, 0);
    chk("rst_fc", s_fc, 0);

    // Release and walk two full frames, comparing against the raster formula
    reset = 1'b1;
    fe_cnt = 0; hs_low = 0; vs_low = 0; von_cnt = 0;
    fe_n_first = -1; fe_n_second = -1;
    for (int n = 1; n <= 2 * 2 * FP + 20; n++) begin
      step();
      p  = n / 2;
      ex = p % HT;
      ey = (p / HT) % VT;
`ifdef VGA_FRAME_COUNT_EN
      exp_fc = 16'(p / FP);
`else
      exp_fc = 16'd0;
`endif
      if (n == 1) begin
        chk("first_edge_tick", s_tick, 1);
        chk("first_edge_x", s_x, 0);
      end
      if (n == 2) chk("second_edge_x", s_x, 1);
      chk("tick", s_tick, n % 2);
      chk("x", s_x, ex);
      chk("y", s_y, ey);
      chk("hsync", s_hs, (ex >= HV + HF && ex < HV + HF + HS) ? 0 : 1);
      chk("vsync", s_vs, (ey >= VV + VF && ey < VV + VF + VS) ? 0 : 1);
      chk("video_on", s_von, (ex < HV && ey < VV) ? 1 : 0);
      chk("frame_end", s_fe, ((n % 2 == 1) && (p % FP == VV * HT)) ? 1 : 0);
      chk("frame_count", s_fc, exp_fc);
      if (n <= 2 * FP) begin
        if (!s_hs) hs_low++;
        if (!s_vs) vs_low++;
        if (s_von) von_cnt++;
        if (s_fe) fe_cnt++;
      end
      if (s_fe) begin
        chk("fe_pos_x", s_x, 0);
        chk("fe_pos_y", s_y, VV);
        if (fe_n_first < 0) fe_n_first = n;
        else if (fe_n_second < 0) fe_n_second = n;
      end
    end
    chk("frame_hs_low_clk", hs_low, 2 * HS * VT);
    chk("frame_vs_low_clk", vs_low, 2 * VS * HT);
    chk("frame_von_clk", von_cnt, 2 * HV * VV);
    chk("frame_fe_pulses", fe_cnt, 1);
    chk("fe_period", fe_n_second - fe_n_first, 2 * FP);

    // Reach x=11, y=5: inside both sync pulses
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (s_x == 10'd11 && s_y == 10'd5) found = 1'b1;
    end
    chk("reach_mid_sync", found, 1);
    chk("mid_hs_low", s_hs, 0);
    chk("mid_vs_low", s_vs, 0);
    #1 reset = 1'b0;
    #1;
    chk("async_hs", s_hs, 1);
    chk("async_vs", s_vs, 1);
    chk("async_x", s_x, 0);
    chk("async_y", s_y, 0);
    chk("async_tick", s_tick, 0);
    chk("async_fc", s_fc, 0);
    repeat (10) step();
    chk("def_rst_x", d_x, 0);
    chk("def_rst_hs", d_hs, 1);

    // Default 640x480 timing: one full line
    reset = 1'b1;
    def_first_x = -1; def_low = 0;
    for (int n = 1; n <= 1700; n++) begin
      step();
      if (n <= 1600 && !d_hs) begin
        def_low++;
        if (def_first_x < 0) def_first_x = int'(d_x);
      end
      if (n == 2) chk("def_second_edge_x", d_x, 1);
      if (n == 1599) begin
        chk("def_line_end_x", d_x, 799);
        chk("def_line_end_y", d_y, 0);
      end
      if (n == 1600) begin
        chk("def_wrap_x", d_x, 0);
        chk("def_wrap_y", d_y, 1);
        chk("def_vs", d_vs, 1);
        chk("def_fc", d_fc, 0);
      end
    end
    chk("def_hs_start_x", def_first_x, 656);
    chk("def_hs_low_clk", def_low, 192);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
